// File: rtl/score_bcd_decode_pkg.sv
// Shared constants and types for the BCD <-> binary score paths.
// The display path imports the same digit order and widths.
package score_bcd_decode_pkg;
  localparam int DIGITS    = 3;
  localparam int DIGIT_W   = 4;
  localparam int SCORE_W   = 10;
  localparam int ACC_W     = SCORE_W + 4;
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAX_DIGIT = 9;
  localparam int SCORE_MAX = 999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp the wide accumulator into the score width.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [ACC_W-1:0] v);
    if (|v[ACC_W-1:SCORE_W]) return '1;
    return v[SCORE_W-1:0];
  endfunction
endpackage

// File: rtl/score_bcd_decode_if.sv
// Start/done handshake and data bundle for the BCD-to-binary decoder.
interface score_bcd_decode_if;
  import score_bcd_decode_pkg::*;

  logic                      start;
  logic [DIGITS*DIGIT_W-1:0] digits;
  logic                      busy;
  logic                      done;
  logic [SCORE_W-1:0]        score;
  logic                      err;

  modport master (output start, output digits,
                  input busy, input done, input score, input err);
  modport slave  (input start, input digits,
                  output busy, output done, output score, output err);
endinterface

// File: rtl/score_bcd_decode_mac.sv
// One multiply-by-ten-and-add step; out-of-range digits contribute zero.
module score_bcd_decode_mac
  import score_bcd_decode_pkg::*;
(
  input  logic [ACC_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [ACC_W-1:0]   acc_next,
  output logic               digit_ok
);
  logic [ACC_W-1:0] addend;

  assign digit_ok = (digit <= DIGIT_W'(MAX_DIGIT));
  assign addend   = digit_ok ? ACC_W'(digit) : '0;
  assign acc_next = (acc << 3) + (acc << 1) + addend;
endmodule

// File: rtl/score_bcd_decode.sv
// Sequential BCD-to-binary score decoder, one digit per cycle, MSD first.
//   state | meaning
//   IDLE  | waiting for start; digits latched on accept
//   CONV  | one digit folded into acc per cycle, idx counts down
//   DONE  | one-cycle done pulse; score/err already updated
module score_bcd_decode
  import score_bcd_decode_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  score_bcd_decode_if.slave  bus
);
  state_t                    state, state_next;
  logic [DIGITS*DIGIT_W-1:0] digits_q;
  logic [IDX_W-1:0]          idx;
  logic [ACC_W-1:0]          acc, acc_next;
  logic [DIGIT_W-1:0]        digit_cur;
  logic                      digit_ok, err_int, err_final, last_digit;
  logic [SCORE_W-1:0]        score_q;
  logic                      err_q, busy, done;

  assign digit_cur  = digits_q[idx*DIGIT_W +: DIGIT_W];
  assign last_digit = (idx == '0);
  assign err_final  = err_int | ~digit_ok;

  score_bcd_decode_mac u_mac (
    .acc      (acc),
    .digit    (digit_cur),
    .acc_next (acc_next),
    .digit_ok (digit_ok)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CONV;
      CONV:    if (last_digit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CONV:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Result registers load on the last CONV edge so they are valid with done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits_q <= '0;
      idx      <= '0;
      acc      <= '0;
      err_int  <= 1'b0;
      score_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          digits_q <= bus.digits;
          acc      <= '0;
          idx      <= IDX_W'(DIGITS - 1);
          err_int  <= 1'b0;
        end
        CONV: begin
          acc     <= acc_next;
          err_int <= err_final;
          if (!last_digit) idx <= idx - 1'b1;
          else begin
            score_q <= err_final ? '0 : sat_score(acc_next);
            err_q   <= err_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.score = score_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_score_bcd_decode.sv
// Directed bench for score_bcd_decode with hand-computed expected scores.
module tb_score_bcd_decode;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;

  score_bcd_decode_if bus ();

  score_bcd_decode dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start pulse accepted on edge 0; busy after edges 0..3, done after edge 3.
  task automatic run_conv(input logic [11:0] d, input logic [9:0] exp_score,
                          input logic exp_err, input string tag);
    bus.digits = d;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    chk({tag, "_busy0"}, bus.busy, 1);
    chk({tag, "_done0"}, bus.done, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_done"}, bus.done, (i == 3) ? 1 : 0);
    end
    chk({tag, "_score"}, bus.score, exp_score);
    chk({tag, "_err"}, bus.err, exp_err);
    step();
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_idle_done"}, bus.done, 0);
    chk({tag, "_hold"}, bus.score, exp_score);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.digits = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_err", bus.err, 0);
    #3 resetn = 1'b1;
    step();

    run_conv(12'h999, 10'd999, 1'b0, "c999");
    run_conv(12'h000, 10'd0,   1'b0, "c000");
    run_conv(12'h512, 10'd512, 1'b0, "c512");
    run_conv(12'h007, 10'd7,   1'b0, "c007");
    run_conv(12'h3A5, 10'd0,   1'b1, "c3a5");
    run_conv(12'h042, 10'd42,  1'b0, "c042");

    // Start held high: accepts on edges 0, 5, 10; digits disturbed mid-CONV.
    bus.digits = 12'h123;
    bus.start  = 1'b1;
    step();
    chk("cont_busy_e0", bus.busy, 1);
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 1 || e == 6)  bus.digits = 12'h456;
      if (e == 4 || e == 9)  bus.digits = 12'h123;
      chk("cont_busy", bus.busy, ((e % 5) != 4) ? 1 : 0);
      chk("cont_done", bus.done, (e == 3 || e == 8 || e == 13) ? 1 : 0);
      if (e == 3 || e == 8 || e == 13) chk("cont_score", bus.score, 123);
    end
    bus.start = 1'b0;
    step();

    // Reset during the second CONV cycle aborts the request.
    bus.digits = 12'h999;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    step();
    #1 resetn = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_score", bus.score, 0);
    chk("abort_err", bus.err, 0);
    #2 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", bus.done, 0);
      chk("abort_no_busy", bus.busy, 0);
    end

    run_conv(12'h512, 10'd512, 1'b0, "post_rst");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_done", bus.done, 0);
      chk("idle_score", bus.score, 512);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
